// File: rtl/simplerisc_ex_stage_if.sv
// Operand-fetch to execute bundle for the SimpleRISC pipeline, including the
// stall handshake that the execute stage returns to operand fetch.
interface simplerisc_ex_stage_if;
  logic        in_valid;
  logic [31:0] pc_in;
  logic [31:0] instruction_in;
  logic [21:0] control_signals_in;
  logic [31:0] branch_target_in;
  logic [31:0] op1_in;
  logic [31:0] op2_in;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        stall_out;

  modport master (
    output in_valid, pc_in, instruction_in, control_signals_in,
           branch_target_in, op1_in, op2_in, a_in, b_in,
    input  stall_out
  );

  modport slave (
    input  in_valid, pc_in, instruction_in, control_signals_in,
           branch_target_in, op1_in, op2_in, a_in, b_in,
    output stall_out
  );
endinterface

// File: rtl/simplerisc_ex_stage.sv
// SimpleRISC execute stage: ALU, branch resolution, EX/MA latch and an iterative
// radix-2 mul/div engine. Define EX_FAST_MUL_EN for a single-cycle multiply.
module simplerisc_ex_stage #(
  parameter int unsigned ITER_CYCLES = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  simplerisc_ex_stage_if.slave       of_bus,
  output logic                       branch_taken,
  output logic [31:0]                branch_pc,
  output logic                       ex_valid,
  output logic [31:0]                ex_pc,
  output logic [31:0]                ex_instruction,
  output logic [21:0]                ex_control,
  output logic [31:0]                ex_alu_result,
  output logic [31:0]                ex_op2,
  output logic                       flag_e,
  output logic                       flag_gt
);
  localparam int unsigned C_ST = 0, C_LD = 1, C_BEQ = 2, C_BGT = 3, C_RET = 4;
  localparam int unsigned C_UB = 7, C_ADD = 9, C_SUB = 10, C_CMP = 11, C_MUL = 12;
  localparam int unsigned C_DIV = 13, C_MOD = 14, C_LSL = 15, C_LSR = 16, C_ASR = 17;
  localparam int unsigned C_OR = 18, C_AND = 19, C_NOT = 20, C_MOV = 21;
  localparam int unsigned CW = $clog2(ITER_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;

  logic [21:0]   ctl;
  logic [31:0]   a, b;
  logic          is_iter, stall, accept;
  logic [31:0]   alu_res;
  logic [CW-1:0] cnt;
  logic [31:0]   acc, q, dvs, s_pc, s_instr, s_op2, s_a;
  logic [21:0]   s_ctl;
  logic          b_zero, q_neg, r_neg;
  logic [32:0]   trial, diff;
  logic [31:0]   iter_res;

  assign ctl = of_bus.control_signals_in;
  assign a   = of_bus.a_in;
  assign b   = of_bus.b_in;

`ifdef EX_FAST_MUL_EN
  assign is_iter = ctl[C_DIV] | ctl[C_MOD];
`else
  assign is_iter = ctl[C_DIV] | ctl[C_MOD] | ctl[C_MUL];
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    unique case (state)
      IDLE: if (of_bus.in_valid && is_iter) begin
        stall    = 1'b1;
        state_nx = BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt == CW'(ITER_CYCLES - 1)) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign of_bus.stall_out = stall;
  // The DONE cycle consumes the held iterative instruction, so it is not a new accept.
  assign accept       = of_bus.in_valid && !stall && (state == IDLE);
  assign branch_taken = accept & (ctl[C_UB] | (ctl[C_BEQ] & flag_e) | (ctl[C_BGT] & flag_gt));
  assign branch_pc    = ctl[C_RET] ? of_bus.op1_in : of_bus.branch_target_in;

  always_comb begin
    alu_res = '0;
    if (ctl[C_ADD] || ctl[C_LD] || ctl[C_ST]) alu_res = a + b;
    else if (ctl[C_SUB] || ctl[C_CMP])        alu_res = a - b;
`ifdef EX_FAST_MUL_EN
    else if (ctl[C_MUL])                      alu_res = a * b;
`endif
    else if (ctl[C_LSL])                      alu_res = a << b[4:0];
    else if (ctl[C_LSR])                      alu_res = a >> b[4:0];
    else if (ctl[C_ASR])                      alu_res = $signed(a) >>> b[4:0];
    else if (ctl[C_OR])                       alu_res = a | b;
    else if (ctl[C_AND])                      alu_res = a & b;
    else if (ctl[C_NOT])                      alu_res = ~b;
    else if (ctl[C_MOV])                      alu_res = b;
  end

  // Restoring division on magnitudes: acc is the partial remainder, q shifts the
  // dividend out and the quotient in. For mul, q is the multiplier, dvs the multiplicand.
  assign trial = {acc, q[31]};
  assign diff  = trial - {1'b0, dvs};

  always_comb begin
    iter_res = acc;
    if (s_ctl[C_DIV])      iter_res = b_zero ? '1  : (q_neg ? -q : q);
    else if (s_ctl[C_MOD]) iter_res = b_zero ? s_a : (r_neg ? -acc : acc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0; acc <= '0; q <= '0; dvs <= '0;
      s_pc <= '0; s_instr <= '0; s_op2 <= '0; s_a <= '0; s_ctl <= '0;
      b_zero <= 1'b0; q_neg <= 1'b0; r_neg <= 1'b0;
    end else if (state == IDLE && state_nx == BUSY) begin
      cnt     <= '0;
      acc     <= '0;
      s_pc    <= of_bus.pc_in;
      s_instr <= of_bus.instruction_in;
      s_op2   <= of_bus.op2_in;
      s_ctl   <= ctl;
      s_a     <= a;
      b_zero  <= (b == '0);
      q_neg   <= a[31] ^ b[31];
      r_neg   <= a[31];
      if (ctl[C_DIV] || ctl[C_MOD]) begin
        q   <= a[31] ? -a : a;
        dvs <= b[31] ? -b : b;
      end else begin
        q   <= b;
        dvs <= a;
      end
    end else if (state == BUSY) begin
      cnt <= cnt + 1'b1;
      if (s_ctl[C_DIV] || s_ctl[C_MOD]) begin
        acc <= diff[32] ? trial[31:0] : diff[31:0];
        q   <= {q[30:0], ~diff[32]};
      end else begin
        if (q[0]) acc <= acc + dvs;
        dvs <= dvs << 1;
        q   <= q >> 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0; ex_pc <= '0; ex_instruction <= '0; ex_control <= '0;
      ex_alu_result <= '0; ex_op2 <= '0; flag_e <= 1'b0; flag_gt <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (stall) begin
            ex_valid <= 1'b0;
          end else if (of_bus.in_valid) begin
            ex_valid       <= 1'b1;
            ex_pc          <= of_bus.pc_in;
            ex_instruction <= of_bus.instruction_in;
            ex_control     <= ctl;
            ex_alu_result  <= alu_res;
            ex_op2         <= of_bus.op2_in;
            if (ctl[C_CMP]) begin
              flag_e  <= (a == b);
              flag_gt <= ($signed(a) > $signed(b));
            end
          end else begin
            ex_valid       <= 1'b0;
            ex_instruction <= '0;
            ex_control     <= '0;
          end
        end
        BUSY: ex_valid <= 1'b0;
        DONE: begin
          ex_valid       <= 1'b1;
          ex_pc          <= s_pc;
          ex_instruction <= s_instr;
          ex_control     <= s_ctl;
          ex_alu_result  <= iter_res;
          ex_op2         <= s_op2;
        end
        default: ex_valid <= 1'b0;
      endcase
    end
  end
endmodule

// File: doc/simplerisc_ex_stage.md
Name: simplerisc_ex_stage

Overview:
- Execute stage for the SimpleRISC pipeline.
- Consumes the operand-fetch bundle: pc, instruction, 22-bit control word, immx, branchTarget, op1, op2, A, B.
- Computes the ALU result, resolves branches against a registered flags pair, and registers everything into the EX/MA latch.
- Div and mod are iterative. Mul is iterative unless EX_FAST_MUL_EN is defined. While an iterative op runs, the stage stalls upstream.

Parameters:
- ITER_CYCLES, 32, iterations of the radix-2 mul/div engine; must equal the data width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  OF bundle valid this cycle
- pc_in  in  32  PC of the instruction
- instruction_in  in  32  instruction word
- control_signals_in  in  22  bit0..21 = isSt, isLd, isBeq, isBgt, isRet, isImmediate, isWb, isUbranch, isCall, isAdd, isSub, isCmp, isMul, isDiv, isMod, isLsl, isLsr, isAsr, isOr, isAnd, isNot, isMov
- branch_target_in  in  32  PC-relative target
- op1_in  in  32  rs1 value; return address for ret
- op2_in  in  32  store data
- a_in  in  32  ALU operand A
- b_in  in  32  ALU operand B (immx or op2, already muxed)
- stall_out  out  1  upstream must hold the OF bundle
- branch_taken  out  1  combinational redirect to fetch
- branch_pc  out  32  combinational redirect target
- ex_valid  out  1  EX/MA latch valid
- ex_pc  out  32  latched pc
- ex_instruction  out  32  latched instruction
- ex_control  out  22  latched control word
- ex_alu_result  out  32  latched ALU result
- ex_op2  out  32  latched store data
- flag_e  out  1  equal flag
- flag_gt  out  1  greater-than flag

Behaviour:
- Reset: every output register clears to 0; FSM goes to IDLE; flags clear to 0. A reset during BUSY aborts the op, and stall_out is 0 the next cycle.
- Single-cycle ops, result in the latch one edge after acceptance:
  - add/ld/st: A+B
  - sub: A-B
  - cmp: result A-B
  - lsl/lsr/asr: shift by B[4:0]
  - or, and: bitwise
  - not: ~B
  - mov: B
  - No ALU select asserted: result 0
- Accept condition: in_valid=1 and stall_out=0.
- Bubble: in_valid=0 gives ex_valid=0 next edge, with ex_instruction and ex_control forced to 0. The other latch fields hold.
- Flags: updated only on an accepted cmp. E = (A==B). GT = signed(A) > signed(B). An instruction in the cycle after a cmp sees the new flags.
- Branch outputs:
  - branch_taken = accept & (isUbranch | (isBeq & E) | (isBgt & GT)).
  - branch_pc = isRet ? op1_in : branch_target_in.
  - Both are combinational. Branch instructions never stall.
- Iterative FSM: IDLE → BUSY → DONE → IDLE.
  - Cycle T: IDLE with in_valid & (isDiv|isMod|isMul). stall_out=1 combinationally; operands are captured at the edge; counter=0.
  - Cycles T+1..T+ITER_CYCLES: BUSY, one iteration per cycle, stall_out=1.
  - Cycle T+ITER_CYCLES+1: DONE, stall_out=0. The latch captures the result at that edge, and the FSM returns to IDLE.
  - Latency is 34 cycles with the default parameter.
- Arithmetic:
  - mul: low 32 bits of the product.
  - div: signed, truncates toward zero.
  - mod: sign follows the dividend.
  - Divide by zero: quotient 0xFFFFFFFF; remainder = dividend.
  - 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- While stalled: the latch holds its prior contents except ex_valid, which is 0 from the first BUSY edge until the result lands. Upstream changes to the input bundle during BUSY are ignored.
- Wrap-around: add, sub and shifts are modulo 2^32; no overflow flag.

Optional Feature:
- Macro: EX_FAST_MUL_EN.
- Defined: isMul completes in one cycle via combinational multiply, with no stall; div/mod stay iterative.
- Undefined: mul uses the iterative engine, with the latency above.

Test Plan:
- Reset held 2 cycles, then released with in_valid=0 → all outputs 0, stall_out=0, flags 0.
- add A=0x7FFFFFFF, B=1 → ex_alu_result=0x80000000 one edge later; then sub A=5, B=7 → 0xFFFFFFFE.
- cmp A=3, B=3, then beq with branch_target_in=0x40 next cycle → E=1, GT=0, branch_taken=1, branch_pc=0x40. cmp A=-1, B=1 then bgt → branch_taken=0.
- div A=-7, B=2 → stall_out high 33 cycles, ex_alu_result=0xFFFFFFFD. mod same operands → 0xFFFFFFFF. div by 0 → 0xFFFFFFFF.
- ret with op1_in=0x1234 → branch_taken=0 unless isUbranch is also set; with isUbranch=1, branch_pc=0x1234.
- Reset asserted at BUSY cycle 10 of a div → stall_out=0 next cycle, ex_valid=0. Under EX_FAST_MUL_EN, mul 0xFFFF×0x10001 → 0xFFFFFFFF in 1 cycle with no stall.
